// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Also provides the sequential next-PC helper.
package if_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Sequential successor; wraps modulo 2^32 with no overflow flag.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority.
// A bubble clears valid and the instruction but keeps the last PC+4.
module if_id_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_add,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_add
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
      pc_add <= 32'h0;
    end else if (flush) begin
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
      pc_add <= 32'h0;
    end else if (stall) begin
      // NOTE: leaving registers unassigned inside always_ff simply holds them; no latch results.
    end else if (load) begin
      valid  <= 1'b1;
      instr  <= load_instr;
      pc_add <= load_pc_add;
    end else begin
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time,
// and feeds the IF/ID register with the returned word and its PC+4.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        im_req_valid,
  output logic [31:0] im_req_addr,
  input  logic        im_req_ready,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  output logic [31:0] pc_out,
  output logic        if_id_valid,
  output logic [31:0] if_id_im_out,
  output logic [31:0] if_id_pc_add_out
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  hold_buf;
  logic [31:0]  pc_plus;
  logic         load;
  logic [31:0]  load_instr;

  assign pc_plus      = pc_next(pc);
  assign im_req_valid = rst_n && (state == REQ) && !redirect;
  assign im_req_addr  = pc;
  assign pc_out       = pc;

  // A word reaches IF/ID straight from memory in WAIT, or from the hold buffer in HOLD.
  assign load       = !redirect && !stall &&
                      (((state == WAIT) && im_rsp_valid) || (state == HOLD));
  assign load_instr = (state == HOLD) ? hold_buf : im_rsp_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      // NOTE: the single-entry hold buffer is cleared on reset; it is a register, not a RAM.
      hold_buf <= NOP_INSTR;
    end else begin
      unique case (state)
        REQ: begin
          if (redirect)          pc    <= redirect_pc;
          else if (im_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (im_rsp_valid) begin
            if (redirect) begin
              pc    <= redirect_pc;
              state <= REQ;
            end else if (!stall) begin
              pc    <= pc_plus;
              state <= REQ;
            end else begin
              hold_buf <= im_rsp_data;
              state    <= HOLD;
            end
          end else if (redirect) begin
            pc    <= redirect_pc;
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= REQ;
          end else if (!stall) begin
            pc    <= pc_plus;
            state <= REQ;
          end
        end
        DISCARD: begin
          // The cancelled response is still owed by memory; swallow it before refetching.
          if (redirect)     pc    <= redirect_pc;
          if (im_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .stall       (stall),
    .load        (load),
    .load_instr  (load_instr),
    .load_pc_add (pc_plus),
    .valid       (if_id_valid),
    .instr       (if_id_im_out),
    .pc_add      (if_id_pc_add_out)
  );

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the multistage MIPS pipeline: holds the architectural PC, issues one request at a time to instruction memory over a valid/ready handshake, and loads the returned word plus PC+4 into the IF/ID pipeline register. Sits directly upstream of the next-PC selector, which consumes `if_id_pc_add_out` and `if_id_im_out` and returns a redirect target. Handles hazard-unit stalls, branch/jump flushes and in-flight fetch cancellation.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `redirect`  in  1  next-PC selector chose a non-sequential target (Jr | Jump | branch taken).
- `redirect_pc`  in  32  target address, valid when `redirect`=1.
- `stall`  in  1  hazard unit: hold IF/ID contents and PC.
- `flush`  in  1  clear IF/ID to a bubble.
- `im_req_valid`  out  1  fetch request.
- `im_req_addr`  out  32  fetch address (= PC).
- `im_req_ready`  in  1  memory accepts request.
- `im_rsp_valid`  in  1  instruction word returned.
- `im_rsp_data`  in  32  instruction word.
- `pc_out`  out  32  current PC (debug/trace).
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_im_out`  out  32  IF/ID instruction; 32'h0 (nop) when invalid.
- `if_id_pc_add_out`  out  32  IF/ID PC+4 of that instruction.

## Operation
- FSM states: REQ, WAIT, HOLD, DISCARD.
- REQ: `im_req_valid` = !redirect; `im_req_addr` = PC. Handshake (valid & ready) -> WAIT. Redirect -> PC <= `redirect_pc`, stay REQ.
- WAIT: await `im_rsp_valid`. At most one outstanding request.
  - rsp & redirect -> drop word, PC <= `redirect_pc`, -> REQ.
  - rsp & !stall -> IF/ID <= {1, data, PC+4}; PC <= PC+4; -> REQ.
  - rsp & stall -> word into hold buffer; -> HOLD.
  - no rsp & redirect -> PC <= `redirect_pc`; -> DISCARD.
- HOLD: no request issued. Redirect -> discard buffer, PC <= `redirect_pc`, -> REQ. !stall -> IF/ID <= {1, hold, PC+4}; PC <= PC+4; -> REQ.
- DISCARD: wait for the cancelled `im_rsp_valid`, drop it, -> REQ. Further redirects here update PC only.
- IF/ID update priority: flush > stall > load > bubble. Flush: valid <= 0, im_out <= 0, pc_add_out <= 0. Stall: hold. No load and no stall: bubble (valid <= 0, im_out <= 0, pc_add_out held).
- Redirect beats stall for PC. Flush with stall clears IF/ID.
- PC+4 is 32-bit modulo; 32'hFFFF_FFFC -> 32'h0000_0000, no flag.

## Timing
- Reset (rst_n=0 at clk edge): PC=RESET_PC, state=REQ, `im_req_valid`=0 while rst_n=0; IF/ID valid=0, im_out=0, pc_add_out=0; hold buffer cleared. Reset mid-fetch abandons the outstanding request; the stage does not track it, and the memory is reset by the same `rst_n`.
- Best case: request accepted in cycle N, response N+1, IF/ID valid from N+2; next request N+2. Throughput 1 instruction per 2 cycles.
- `im_rsp_valid` is ignored in REQ and HOLD.
- `redirect`, `stall` and `flush` are sampled at the same edge as the handshake. `im_req_valid` depends combinationally on `redirect`; all other outputs are registered.

## Structure
- Shared package `if_pkg`: state enum (REQ, WAIT, HOLD, DISCARD), `NOP_INSTR`=32'h0, `PC_STEP`=4.
- One natural sub-module, `if_id_reg`: the IF/ID register with flush/stall/load/bubble priority. The FSM, PC and hold buffer live in `if_fetch`.

## Test plan
- Reset, memory always ready, 1-cycle response: addresses 0x3000, 0x3004, 0x3008 in order. `if_id_pc_add_out` is 0x3004, 0x3008, 0x300C, each valid every other cycle.
- Stall held 3 cycles while a response arrives: word stays in HOLD, IF/ID unchanged, PC unchanged. After release, the word loads with the correct PC+4 and the next request follows.
- Redirect to 0x4000 while in WAIT, response 2 cycles later: response dropped (DISCARD), next request addr 0x4000, no stale IF/ID load.
- Redirect coincident with response, plus flush: IF/ID becomes valid=0 / im_out=0, next request 0x4000.
- `im_req_ready` low for 5 cycles: `im_req_valid` stays high with a stable address; no IF/ID load until accepted.
- PC=0xFFFF_FFFC fetch completes: `if_id_pc_add_out`=0x0, next request addr 0x0. Reset asserted in WAIT: PC=0x3000, IF/ID cleared next cycle.
